// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for a 5-stage ARM-subset core.
// Decodes the instruction in Decode, carries the resulting controls through
// the Execute, Memory and Writeback stages, holds the condition flags,
// evaluates the condition code in Execute and squashes writes that fail it.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous active-high clear of all pipeline state and flags
//   InstrD        instruction bits [31:12] in Decode
//   ALUFlagsE     {N,Z,C,V} produced by the ALU this cycle
//   FlushE        bubble the Decode->Execute control register
//   RegSrcD       Decode register-source selects
//   ImmSrcD       Decode immediate-format select
//   LinkD         Decode instruction is BL (destination R14)
//   ALUSrcE       Execute immediate operand select
//   BranchTakenE  Execute branch redirect
//   ALUControlE   Execute ALU operation
//   MemtoRegE     Execute load flag for hazard logic
//   MemWriteM     Memory store enable
//   RegWriteM     Memory register-write flag for hazard logic
//   MemtoRegW     Writeback result select
//   PCSrcW        Writeback writes the PC
//   RegWriteW     Writeback register write enable
//   PCWrPendingF  a PC write is in flight in D, E or M
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] InstrD,
  input  logic [3:0]  ALUFlagsE,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        LinkD,
  output logic        ALUSrcE,
  output logic        BranchTakenE,
  output logic [2:0]  ALUControlE,
  output logic        MemtoRegE,
  output logic        MemWriteM,
  output logic        RegWriteM,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        PCWrPendingF
);

  typedef struct packed {
    logic [3:0] cond;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [2:0] alu_control;
    logic       alu_src;
    logic       branch;
    logic       flag_write;
    logic       pcsrc;
    logic       link;
  } de_ctrl_t;

  // InstrD carries instruction bits [31:12], so field offsets are shifted by 12
  logic [3:0] cond_d;
  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] cmd_d;
  logic [3:0] rd_d;

  assign cond_d  = InstrD[19:16];
  assign op_d    = InstrD[15:14];
  assign funct_d = InstrD[13:8];
  assign cmd_d   = funct_d[4:1];
  assign rd_d    = InstrD[3:0];

  logic       dp_valid;
  logic       dp_cmp;
  logic [2:0] dp_alu;

  always_comb begin
    dp_valid = 1'b1;
    dp_cmp   = 1'b0;
    dp_alu   = 3'b000;
    case (cmd_d)
      4'b0100: dp_alu = 3'b000;
      4'b0010: dp_alu = 3'b001;
      4'b0000: dp_alu = 3'b010;
      4'b1100: dp_alu = 3'b011;
      4'b1010: begin
        dp_alu = 3'b001;
        dp_cmp = 1'b1;
      end
      default: dp_valid = 1'b0;
    endcase
  end

  de_ctrl_t de_d;
  de_ctrl_t de_e;
  logic     pcsrc_d;

  always_comb begin
    de_d      = '0;
    RegSrcD   = 2'b00;
    ImmSrcD   = 2'b00;
    LinkD     = 1'b0;
    de_d.cond = cond_d;
    case (op_d)
      2'b00: begin
        // unsupported commands leave every control at zero
        if (dp_valid) begin
          de_d.reg_write   = ~dp_cmp;
          de_d.alu_src     = funct_d[5];
          de_d.alu_control = dp_alu;
          de_d.flag_write  = funct_d[0] | dp_cmp;
        end
      end
      2'b01: begin
        de_d.alu_src = 1'b1;
        ImmSrcD      = 2'b01;
        if (funct_d[0]) begin
          de_d.reg_write  = 1'b1;
          de_d.mem_to_reg = 1'b1;
        end else begin
          de_d.mem_write = 1'b1;
          RegSrcD[1]     = 1'b1;
        end
      end
      2'b10: begin
        de_d.alu_src = 1'b1;
        de_d.branch  = 1'b1;
        ImmSrcD      = 2'b10;
        RegSrcD[0]   = 1'b1;
        if (funct_d[4]) begin
          LinkD          = 1'b1;
          de_d.reg_write = 1'b1;
        end
      end
      default: ;
    endcase
    de_d.link  = LinkD;
    // BL writes R14, never the PC, whatever the Rd field holds
    de_d.pcsrc = (rd_d == 4'hF) && de_d.reg_write && !de_d.branch;
  end

  assign pcsrc_d = de_d.pcsrc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      de_e <= '0;
    else if (FlushE)
      de_e <= '0;
    else
      de_e <= de_d;
  end

  logic [3:0] flags;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_ex_e;

  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex_e = 1'b0;
    case (de_e.cond)
      4'b0000: cond_ex_e = z_f;
      4'b0001: cond_ex_e = ~z_f;
      4'b0010: cond_ex_e = c_f;
      4'b0011: cond_ex_e = ~c_f;
      4'b0100: cond_ex_e = n_f;
      4'b0101: cond_ex_e = ~n_f;
      4'b0110: cond_ex_e = v_f;
      4'b0111: cond_ex_e = ~v_f;
      4'b1000: cond_ex_e = c_f & ~z_f;
      4'b1001: cond_ex_e = ~c_f | z_f;
      4'b1010: cond_ex_e = (n_f == v_f);
      4'b1011: cond_ex_e = (n_f != v_f);
      4'b1100: cond_ex_e = ~z_f & (n_f == v_f);
      4'b1101: cond_ex_e = z_f | (n_f != v_f);
      4'b1110: cond_ex_e = 1'b1;
      default: cond_ex_e = 1'b0;
    endcase
  end

  // Uses the instruction already in E, so a simultaneous flush of the
  // incoming instruction does not suppress this update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags <= 4'b0000;
    else if (de_e.flag_write && cond_ex_e)
      flags <= ALUFlagsE;
  end

  logic reg_write_m, mem_write_m, pcsrc_m, mem_to_reg_m, link_m;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      pcsrc_m      <= 1'b0;
      mem_to_reg_m <= 1'b0;
      link_m       <= 1'b0;
    end else begin
      reg_write_m  <= de_e.reg_write & cond_ex_e;
      mem_write_m  <= de_e.mem_write & cond_ex_e;
      pcsrc_m      <= de_e.pcsrc & cond_ex_e;
      mem_to_reg_m <= de_e.mem_to_reg;
      link_m       <= de_e.link;
    end
  end

  logic reg_write_w, mem_to_reg_w, pcsrc_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      pcsrc_w      <= 1'b0;
    end else begin
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      pcsrc_w      <= pcsrc_m;
    end
  end

  assign ALUSrcE      = de_e.alu_src;
  assign ALUControlE  = de_e.alu_control;
  assign MemtoRegE    = de_e.mem_to_reg;
  assign BranchTakenE = de_e.branch & cond_ex_e;
  assign MemWriteM    = mem_write_m;
  assign RegWriteM    = reg_write_m;
  assign MemtoRegW    = mem_to_reg_w;
  assign PCSrcW       = pcsrc_w;
  assign RegWriteW    = reg_write_w;
  // E term is deliberately ungated: a PC write is assumed pending until resolved
  assign PCWrPendingF = pcsrc_d | de_e.pcsrc | pcsrc_m;

  // Link travels with the instruction but no stage here consumes it past D,
  // and the Rn field is decoded by the datapath, not this block.
  logic unused_bits;
  assign unused_bits = ^{link_m, InstrD[7:4]};

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic [19:0] InstrD;
  logic [3:0]  ALUFlagsE;
  logic        FlushE;
  logic [1:0]  RegSrcD, ImmSrcD;
  logic        LinkD, ALUSrcE, BranchTakenE;
  logic [2:0]  ALUControlE;
  logic        MemtoRegE, MemWriteM, RegWriteM;
  logic        MemtoRegW, PCSrcW, RegWriteW, PCWrPendingF;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [19:0] I_NOP   = 20'hEC000;
  localparam logic [19:0] I_ADD   = 20'hE0811;
  localparam logic [19:0] I_SUBI  = 20'hE2412;
  localparam logic [19:0] I_CMP   = 20'hE1510;
  localparam logic [19:0] I_EOR   = 20'hE0212;
  localparam logic [19:0] I_BEQ   = 20'h08000;
  localparam logic [19:0] I_BL    = 20'hE900F;
  localparam logic [19:0] I_LDRPC = 20'hE410F;
  localparam logic [19:0] I_STRNE = 20'h14002;
  localparam logic [19:0] I_STR   = 20'hE4002;

  pipe_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .InstrD       (InstrD),
    .ALUFlagsE    (ALUFlagsE),
    .FlushE       (FlushE),
    .RegSrcD      (RegSrcD),
    .ImmSrcD      (ImmSrcD),
    .LinkD        (LinkD),
    .ALUSrcE      (ALUSrcE),
    .BranchTakenE (BranchTakenE),
    .ALUControlE  (ALUControlE),
    .MemtoRegE    (MemtoRegE),
    .MemWriteM    (MemWriteM),
    .RegWriteM    (RegWriteM),
    .MemtoRegW    (MemtoRegW),
    .PCSrcW       (PCSrcW),
    .RegWriteW    (RegWriteW),
    .PCWrPendingF (PCWrPendingF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CMP loads flags f, then a branch with condition cc is checked in E
  task automatic branch_case(input string tag, input logic [3:0] f,
                             input logic [3:0] cc, input logic exp);
    InstrD    = I_CMP;
    ALUFlagsE = f;
    tick();
    InstrD = {cc, 16'h8000};
    tick();
    ALUFlagsE = 4'b0000;
    InstrD    = I_NOP;
    #1;
    chk(tag, BranchTakenE, exp);
  endtask

  initial begin
    reset     = 1'b0;
    InstrD    = I_NOP;
    ALUFlagsE = 4'b0000;
    FlushE    = 1'b0;
    #1 reset  = 1'b1;
    #2;
    chk("rst_regwrite_w", RegWriteW, 1'b0);
    chk("rst_memwrite_m", MemWriteM, 1'b0);
    chk("rst_flags", dut.flags, 4'b0000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ADD R1: 3 edges to writeback
    InstrD = I_ADD;
    #1;
    chk("add_regsrc", RegSrcD, 2'b00);
    chk("add_link", LinkD, 1'b0);
    tick();
    InstrD = I_NOP;
    #1;
    chk("add_aluctl_e", ALUControlE, 3'b000);
    chk("add_alusrc_e", ALUSrcE, 1'b0);
    tick();
    chk("add_regwrite_m", RegWriteM, 1'b1);
    chk("add_regwrite_w_early", RegWriteW, 1'b0);
    tick();
    chk("add_regwrite_w", RegWriteW, 1'b1);
    chk("add_memtoreg_w", MemtoRegW, 1'b0);

    // SUB immediate
    InstrD = I_SUBI;
    #1;
    chk("sub_immsrc", ImmSrcD, 2'b00);
    tick();
    InstrD = I_NOP;
    #1;
    chk("sub_aluctl_e", ALUControlE, 3'b001);
    chk("sub_alusrc_e", ALUSrcE, 1'b1);

    // unsupported data-processing command decodes as NOP
    InstrD = I_EOR;
    tick();
    InstrD = I_NOP;
    tick();
    chk("eor_regwrite_m", RegWriteM, 1'b0);

    // CMP sets Z, BEQ taken
    InstrD    = I_CMP;
    ALUFlagsE = 4'b0100;
    tick();
    InstrD = I_BEQ;
    #1;
    chk("cmp_aluctl_e", ALUControlE, 3'b001);
    chk("cmp_flags_before", dut.flags, 4'b0000);
    tick();
    ALUFlagsE = 4'b0000;
    InstrD    = I_NOP;
    #1;
    chk("cmp_flags_after", dut.flags, 4'b0100);
    chk("beq_taken", BranchTakenE, 1'b1);
    chk("cmp_regwrite_m", RegWriteM, 1'b0);
    tick();
    chk("nop_not_taken", BranchTakenE, 1'b0);
    branch_case("beq_not_taken", 4'b0000, 4'b0000, 1'b0);

    // LDR R15
    InstrD = I_LDRPC;
    #1;
    chk("ldr_pcpend_d", PCWrPendingF, 1'b1);
    chk("ldr_pcsrc_d", dut.pcsrc_d, 1'b1);
    chk("ldr_immsrc", ImmSrcD, 2'b01);
    tick();
    InstrD = I_NOP;
    #1;
    chk("ldr_pcpend_e", PCWrPendingF, 1'b1);
    chk("ldr_memtoreg_e", MemtoRegE, 1'b1);
    tick();
    chk("ldr_pcpend_m", PCWrPendingF, 1'b1);
    chk("ldr_regwrite_m", RegWriteM, 1'b1);
    tick();
    chk("ldr_pcpend_w", PCWrPendingF, 1'b0);
    chk("ldr_pcsrc_w", PCSrcW, 1'b1);
    chk("ldr_memtoreg_w", MemtoRegW, 1'b1);
    chk("ldr_regwrite_w", RegWriteW, 1'b1);

    // BL with Rd field 1111 must not flag a PC write
    InstrD = I_BL;
    #1;
    chk("bl_link", LinkD, 1'b1);
    chk("bl_regsrc", RegSrcD, 2'b01);
    chk("bl_immsrc", ImmSrcD, 2'b10);
    chk("bl_pcpend", PCWrPendingF, 1'b0);
    tick();
    InstrD = I_NOP;
    #1;
    chk("bl_taken", BranchTakenE, 1'b1);
    tick();
    tick();
    chk("bl_regwrite_w", RegWriteW, 1'b1);
    chk("bl_pcsrc_w", PCSrcW, 1'b0);

    // STRNE with Z set is squashed
    InstrD    = I_CMP;
    ALUFlagsE = 4'b0100;
    tick();
    InstrD = I_STRNE;
    #1;
    chk("str_regsrc", RegSrcD, 2'b10);
    chk("str_immsrc", ImmSrcD, 2'b01);
    tick();
    ALUFlagsE = 4'b0000;
    InstrD    = I_NOP;
    tick();
    chk("strne_memwrite_m", MemWriteM, 1'b0);

    // STR AL writes memory, never a register
    InstrD = I_STR;
    tick();
    InstrD = I_NOP;
    tick();
    chk("str_memwrite_m", MemWriteM, 1'b1);
    tick();
    chk("str_regwrite_w", RegWriteW, 1'b0);
    chk("str_memwrite_m_done", MemWriteM, 1'b0);

    // flush an STR on its way into E
    InstrD = I_STR;
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    InstrD = I_NOP;
    #1;
    chk("flush_alusrc_e", ALUSrcE, 1'b0);
    tick();
    chk("flush_memwrite_m", MemWriteM, 1'b0);
    tick();
    chk("flush_regwrite_w", RegWriteW, 1'b0);
    chk("flush_flags", dut.flags, 4'b0100);

    // flush while a flag-setting CMP sits in E
    InstrD    = I_CMP;
    ALUFlagsE = 4'b0010;
    tick();
    FlushE = 1'b1;
    InstrD = I_ADD;
    tick();
    FlushE    = 1'b0;
    InstrD    = I_NOP;
    ALUFlagsE = 4'b0000;
    #1;
    chk("flushcmp_flags", dut.flags, 4'b0010);
    tick();
    chk("flushcmp_regwrite_m", RegWriteM, 1'b0);

    // condition codes
    branch_case("cc_ne",    4'b0000, 4'b0001, 1'b1);
    branch_case("cc_hi_t",  4'b0010, 4'b1000, 1'b1);
    branch_case("cc_hi_f",  4'b0110, 4'b1000, 1'b0);
    branch_case("cc_ls",    4'b0110, 4'b1001, 1'b1);
    branch_case("cc_ge",    4'b1001, 4'b1010, 1'b1);
    branch_case("cc_lt",    4'b1000, 4'b1011, 1'b1);
    branch_case("cc_gt_f",  4'b1000, 4'b1100, 1'b0);
    branch_case("cc_gt_t",  4'b0000, 4'b1100, 1'b1);
    branch_case("cc_le",    4'b0100, 4'b1101, 1'b1);
    branch_case("cc_nv",    4'b0000, 4'b1111, 1'b0);
    branch_case("cc_mi",    4'b1000, 4'b0100, 1'b1);
    branch_case("cc_vc",    4'b0001, 4'b0111, 1'b0);
    branch_case("cc_cc",    4'b0010, 4'b0011, 1'b0);

    // reset while an LDR sits in M (flags hold 0010 here)
    InstrD = I_LDRPC;
    tick();
    InstrD = I_NOP;
    tick();
    chk("prerst_regwrite_m", RegWriteM, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_regwrite_m", RegWriteM, 1'b0);
    chk("midrst_regwrite_w", RegWriteW, 1'b0);
    chk("midrst_memtoreg_w", MemtoRegW, 1'b0);
    chk("midrst_flags", dut.flags, 4'b0000);
    chk("midrst_pcpend", PCWrPendingF, 1'b0);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_regwrite_w", RegWriteW, 1'b0);
      chk("postrst_memtoreg_w", MemtoRegW, 1'b0);
    end
    chk("postrst_flags", dut.flags, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 InstrD  input  20  InstrD[31:12] of Decode-stage instruction: cond[31:28], op[27:26], funct[25:20], Rd[15:12].
REQ-004 ALUFlagsE  input  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-005 FlushE  input  1  from hazard unit; bubbles the D->E control register.
REQ-006 RegSrcD, ImmSrcD  output  2 each  Decode-stage source-register and immediate-format selects.
REQ-007 LinkD  output  1  Decode instruction is BL; destination becomes R14.
REQ-008 ALUSrcE, BranchTakenE  output  1 each  Execute-stage immediate select; branch redirect.
REQ-009 ALUControlE  output  3  Execute-stage ALU operation.
REQ-010 MemWriteM, RegWriteM  output  1 each  Memory-stage store enable; register-write flag used by hazard logic.
REQ-011 MemtoRegE  output  1  Execute-stage load flag used by hazard logic.
REQ-012 MemtoRegW, PCSrcW, RegWriteW  output  1 each  Writeback-stage controls.
REQ-013 PCWrPendingF  output  1  a write to R15 is in flight in D, E or M.

Function
REQ-014 Decode (combinational from InstrD) SHALL use op: 00 data-processing, 01 LDR/STR, 10 B/BL; op 11 SHALL decode as all-zero controls (NOP).
REQ-015 Data-processing: I=funct[5], cmd=funct[4:1], S=funct[0]; ADD 0100->000, SUB 0010->001, AND 0000->010, ORR 1100->011, CMP 1010->001 with RegWrite=0 and FlagWrite=1; any other cmd decodes as NOP.
REQ-016 Data-processing: RegWrite=1 (except CMP), ALUSrc=I, ImmSrc=00, RegSrc=00, FlagWrite=S (forced 1 for CMP).
REQ-017 Memory: ALUControl=000, ALUSrc=1, ImmSrc=01; L=funct[0]: LDR -> RegWrite=1, MemtoReg=1; STR -> MemWrite=1, RegSrc[1]=1.
REQ-018 Branch: ALUControl=000, ALUSrc=1, ImmSrc=10, RegSrc[0]=1, Branch=1; funct[4]=1 -> BL: LinkD=1, RegWrite=1.
REQ-019 PCSrc SHALL be 1 iff Rd==1111 and RegWrite=1, for non-branch instructions.
REQ-020 D->E register SHALL hold {cond, RegWrite, MemtoReg, MemWrite, ALUControl, ALUSrc, Branch, FlagWrite, PCSrc, Link}; FlushE=1 SHALL load all-zero (cond=0000) on the edge.
REQ-021 Flags register (4 bits) SHALL be read in Execute; condition CondExE evaluated from condE and flags: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per ARM; 1110 always true; 1111 false.
REQ-022 Flags register SHALL load ALUFlagsE on the edge iff FlagWriteE & CondExE.
REQ-023 RegWrite, MemWrite, PCSrc SHALL be gated by CondExE before entering E->M register; MemtoReg, Link pass ungated.
REQ-024 BranchTakenE = BranchE & CondExE (combinational, same cycle).
REQ-025 E->M and M->W registers SHALL advance every cycle (no enable); latency Decode to Writeback = 3 edges.
REQ-026 PCWrPendingF = PCSrcD | PCSrcE | PCSrcM (PCSrcE ungated).
REQ-027 Simultaneous FlushE and flag-setting instruction in E: flag update uses the current E contents; flush affects only the incoming D->E load.

Reset
REQ-028 reset=1 SHALL clear D->E, E->M, M->W registers and flags to 0 asynchronously; all registered outputs 0 while reset held.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight controls; no write is produced after reset release until a new instruction traverses 3 edges.

Verification
REQ-030 ADD R1 (InstrD=E0811 cond AL, Rd=1) -> RegWriteW=1, MemtoRegW=0, ALUControlE=000 exactly 3 edges after decode.
REQ-031 CMP (S=1) with ALUFlagsE=0100, then BEQ -> flags=0100, BranchTakenE=1 in branch's E cycle; with flags 0000 -> BranchTakenE=0.
REQ-032 LDR R15 -> PCSrcD=1; PCWrPendingF=1 for 3 consecutive cycles; PCSrcW=1, MemtoRegW=1 at W.
REQ-033 BL (cond AL) -> LinkD=1, BranchTakenE=1, RegWriteW=1; STR with cond NE and Z=1 -> MemWriteM=0.
REQ-034 FlushE=1 on the edge an STR enters E -> MemWriteM=0, RegWriteW=0 on following cycles; flags unchanged.
REQ-035 reset pulsed while LDR in M -> RegWriteW, MemtoRegW, flags read 0 immediately and stay 0 after release.
